// File: rtl/riscv_lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, func3 codes,
// default bus timeout and the access legality check used when a request is accepted.
package riscv_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } lsu_state_t;

    localparam int LSU_TIMEOUT_DEFAULT = 16;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // func3[1:0] encodes the access size for every legal code, loads and stores alike.
    function automatic logic access_legal(input logic       is_store,
                                          input logic [2:0] f3,
                                          input logic [1:0] addr_lo);
        logic size_ok;
        logic aligned;
        if (is_store)
            size_ok = f3 inside {F3_SB, F3_SH, F3_SW};
        else
            size_ok = f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        case (f3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~addr_lo[0];
            2'b10:   aligned = (addr_lo == 2'b00);
            default: aligned = 1'b0;
        endcase
        return size_ok && aligned;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-wide req/ack memory port between the load/store unit (master) and memory (slave).
interface load_store_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
                    input  bus_rdata, bus_ack);
    modport slave  (input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
                    output bus_rdata, bus_ack);
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store strobes/replication and load lane select
// with sign or zero extension.
module lsu_lane_align
    import riscv_lsu_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  byte_off,
    input  logic        is_store,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = load_word[{byte_off, 3'b000} +: 8];
    assign half_lane = load_word[{byte_off[1], 4'b0000} +: 16];

    always_comb begin
        wstrb = 4'b0000;
        wdata = store_data;
        if (is_store) begin
            case (func3[1:0])
                2'b00: begin
                    wstrb = 4'b0001 << byte_off;
                    wdata = {4{store_data[7:0]}};
                end
                2'b01: begin
                    wstrb = 4'b0011 << byte_off;
                    wdata = {2{store_data[15:0]}};
                end
                default: wstrb = 4'b1111;
            endcase
        end
    end

    always_comb begin
        case (func3)
            F3_LB:   load_data = {{24{byte_lane[7]}}, byte_lane};
            F3_LH:   load_data = {{16{half_lane[15]}}, half_lane};
            F3_LBU:  load_data = {24'h000000, byte_lane};
            F3_LHU:  load_data = {16'h0000, half_lane};
            default: load_data = load_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core memory request at a time, checks legality,
// runs a req/ack bus transaction with timeout, and returns extended load data.
//
//   state | meaning
//   IDLE  | waiting for mem_read/mem_write; stall follows the request
//   BUSY  | bus_req high, waiting for bus_ack, timeout timer running
//   DONE  | one-cycle completion, core request ignored
//   FAULT | one-cycle fault pulse (illegal, misaligned or timed out)
module load_store_unit
    import riscv_lsu_pkg::*;
#(
    parameter int TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  func3,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        fault,
    load_store_unit_if.master bus
);

    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TC_LOAD = CNT_W'(TIMEOUT - 1);

    lsu_state_t        state, state_nx;
    logic [CNT_W-1:0]  timer;
    logic [31:0]       lat_addr;
    logic [31:0]       lat_data;
    logic [2:0]        lat_func3;
    logic              lat_we;
    logic              bus_req_q;
    logic              accept;
    logic              req_legal;
    logic [31:0]       load_data;

    assign req_legal = access_legal(mem_write, func3, address[1:0]);

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    stall = 1'b1;
                    if (req_legal) begin
                        state_nx = BUSY;
                        accept   = 1'b1;
                    end else begin
                        state_nx = FAULT;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                // An ack on the terminal-count cycle still completes the access.
                if (bus.bus_ack)
                    state_nx = DONE;
                else if (timer == '0)
                    state_nx = FAULT;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            timer     <= '0;
            bus_req_q <= 1'b0;
            lat_addr  <= '0;
            lat_data  <= '0;
            lat_func3 <= '0;
            lat_we    <= 1'b0;
            read_data <= '0;
        end else begin
            state     <= state_nx;
            bus_req_q <= (state_nx == BUSY);
            if (accept) begin
                timer     <= TC_LOAD;
                lat_addr  <= address;
                lat_data  <= write_data;
                lat_func3 <= func3;
                lat_we    <= mem_write;
            end else if (state == BUSY && timer != '0) begin
                timer <= timer - 1'b1;
            end
            if (state == BUSY && bus.bus_ack && !lat_we)
                read_data <= load_data;
        end
    end

    lsu_lane_align u_lane_align (
        .func3      (lat_func3),
        .byte_off   (lat_addr[1:0]),
        .is_store   (lat_we),
        .store_data (lat_data),
        .load_word  (bus.bus_rdata),
        .wstrb      (bus.bus_wstrb),
        .wdata      (bus.bus_wdata),
        .load_data  (load_data)
    );

    assign fault        = (state == FAULT);
    assign bus.bus_req  = bus_req_q;
    assign bus.bus_we   = lat_we;
    assign bus.bus_addr = {lat_addr[31:2], 2'b00};

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, max cycles spent waiting for bus_ack before a fault.
REQ-002 SHALL have port clock, input, 1, the single clock; all state on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port mem_read, input, 1, core requests a load.
REQ-005 SHALL have port mem_write, input, 1, core requests a store.
REQ-006 SHALL have port func3, input, 3, access size/sign code from the instruction.
REQ-007 SHALL have port address, input, 32, byte address from ALU result.
REQ-008 SHALL have port write_data, input, 32, store data (rs2).
REQ-009 SHALL have port read_data, output, 32, extended load result to the result mux.
REQ-010 SHALL have port stall, output, 1, high while the core must hold PC and register writes.
REQ-011 SHALL have port fault, output, 1, one-cycle pulse on misalignment, illegal func3 or timeout.
REQ-012 SHALL have ports bus_req, bus_we, bus_addr[31:0], bus_wdata[31:0], bus_wstrb[3:0] as outputs, and bus_rdata[31:0], bus_ack as inputs, forming a word-wide req/ack memory port.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE, FAULT.
REQ-014 IDLE: on mem_write or mem_read with legal aligned access SHALL go to BUSY, latching address, func3, data, direction; mem_write SHALL win if both are high.
REQ-015 IDLE: illegal func3 (loads: 011,110,111; stores: anything but 000,001,010) or misalignment (half with address[0]=1, word with address[1:0]!=0) SHALL go to FAULT with no bus transaction.
REQ-016 stall SHALL be high combinationally in IDLE while a request is present, and throughout BUSY; low in DONE, FAULT and idle-without-request.
REQ-017 bus_req SHALL be registered, high from the first BUSY cycle until the cycle after bus_ack is sampled high; bus_addr = {address[31:2],2'b00}.
REQ-018 Store lanes: sb wstrb = 4'b0001<<address[1:0], wdata = byte replicated x4; sh wstrb = 4'b0011<<address[1:0], wdata = half replicated x2; sw wstrb = 4'b1111; loads drive wstrb = 0, bus_we = 0.
REQ-019 Loads SHALL select the lane by address[1:0] and extend: 000 lb sign, 001 lh sign, 010 lw, 100 lbu zero, 101 lhu zero.
REQ-020 bus_ack in BUSY SHALL move to DONE; read_data SHALL be registered from bus_rdata at that edge and held until the next load completes.
REQ-021 DONE SHALL last exactly one cycle, ignore the still-present core request, and return to IDLE.
REQ-022 A BUSY-cycle counter SHALL go to FAULT when it reaches TIMEOUT without ack, dropping bus_req; bus_ack sampled in the same cycle the count reaches TIMEOUT SHALL win (DONE).
REQ-023 FAULT SHALL last one cycle with fault=1, read_data unchanged, then IDLE.
REQ-024 bus_ack outside BUSY SHALL be ignored.
REQ-025 Minimum latency: request in cycle 0, bus_req cycle 1, ack cycle 1 gives DONE in cycle 2.

Reset
REQ-026 reset low SHALL asynchronously force IDLE, counter 0, bus_req 0, read_data 0, fault 0; stall then follows REQ-016.
REQ-027 Reset mid-BUSY SHALL abort the transaction; a later stray ack SHALL be ignored.

Structure
REQ-028 Package riscv_lsu_pkg SHALL hold the state enum, func3 load/store constants and default TIMEOUT.
REQ-029 Lane select, wstrb generation and sign/zero extension SHALL live in combinational sub-module lsu_lane_align.

Verification
REQ-030 sw address 0x100, data 0xDEADBEEF, ack after 3 cycles -> bus_addr 0x100, wstrb 1111, stall for 4 cycles, no fault.
REQ-031 lb address 0x203, bus_rdata 0x80FFFFFF -> read_data 0xFFFFFF80; lbu -> 0x00000080.
REQ-032 sh address 0x102, data 0x0000ABCD -> wstrb 1100, wdata 0xABCDABCD.
REQ-033 lw address 0x101 -> fault pulse, bus_req never high, stall low next cycle.
REQ-034 lw with no ack, TIMEOUT=16 -> fault 16 cycles after bus_req rises, bus_req drops.
REQ-035 reset low during BUSY, then ack -> IDLE, read_data 0, no DONE.
